// File: rtl/gshare_bht_pkg.sv
// rtl/gshare_bht_pkg.sv - shared gshare branch predictor types, constants and index function
package gshare_bht_pkg;

  typedef struct packed {
    logic       valid;
    logic [1:0] cnt;
  } bht_entry_t;

  localparam logic [1:0] WEAK_NT = 2'b01;
  localparam logic [1:0] WEAK_T  = 2'b10;

  // pc[ofs+idx_w-1:ofs] ^ hist, with hist already narrower than the index
  function automatic logic [31:0] gshare_idx(input logic [63:0] pc,
                                             input logic [31:0] hist,
                                             input int          idx_w,
                                             input int          ofs);
    return 32'(((pc >> ofs) ^ 64'(hist)) & ((64'd1 << idx_w) - 64'd1));
  endfunction

endpackage

// File: rtl/gshare_bht_sat_counter2.sv
// rtl/gshare_bht_sat_counter2.sv - next-value logic for a 2-bit saturating direction counter
module sat_counter2
  import gshare_bht_pkg::*;
(
  input  logic       valid_i,
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (!valid_i) begin
      // first allocation lands on the weak side of the observed direction
      cnt_o = taken_i ? WEAK_T : WEAK_NT;
    end else if (taken_i) begin
      cnt_o = (cnt_i == 2'b11) ? cnt_i : cnt_i + 2'd1;
    end else begin
      cnt_o = (cnt_i == 2'b00) ? cnt_i : cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/gshare_bht.sv
// rtl/gshare_bht.sv - gshare branch history table with speculative GHR and mispredict restore
module gshare_bht
  import gshare_bht_pkg::*;
#(
  parameter int VLEN    = 32,
  parameter int ENTRIES = 32,
  parameter int HIST    = 3,
  parameter bit RVC     = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_bp_i,
  input  logic            debug_mode_i,
  input  logic [VLEN-1:0] vpc_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  output logic [HIST-1:0] pred_ghr_o,
  input  logic            spec_push_i,
  input  logic            spec_taken_i,
  input  logic            res_valid_i,
  input  logic [VLEN-1:0] res_pc_i,
  input  logic            res_taken_i,
  input  logic            res_mispredict_i,
  input  logic [HIST-1:0] res_ghr_i
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OFS   = RVC ? 1 : 2;

  if (HIST < 1 || HIST > IDX_W) begin : g_hist_range_chk
    $error("gshare_bht: HIST must satisfy 1 <= HIST <= IDX_W");
  end

  bht_entry_t table_q [ENTRIES];
  bht_entry_t table_d [ENTRIES];
  logic [HIST-1:0] ghr_q, ghr_d;

  logic [31:0]      lk_raw, res_raw;
  logic [IDX_W-1:0] lk_idx, res_idx;
  logic [1:0]       upd_cnt;
  logic [HIST:0]    restore_shift, spec_shift;
  logic             unused_idx_hi;

  assign lk_raw  = gshare_idx(64'(vpc_i), 32'(ghr_q), IDX_W, OFS);
  assign res_raw = gshare_idx(64'(res_pc_i), 32'(res_ghr_i), IDX_W, OFS);
  assign lk_idx  = lk_raw[IDX_W-1:0];
  assign res_idx = res_raw[IDX_W-1:0];
  assign unused_idx_hi = ^{lk_raw[31:IDX_W], res_raw[31:IDX_W]};

  assign pred_valid_o = table_q[lk_idx].valid;
  assign pred_taken_o = table_q[lk_idx].cnt[1];
  assign pred_ghr_o   = ghr_q;

  sat_counter2 u_sat_counter2 (
    .valid_i (table_q[res_idx].valid),
    .cnt_i   (table_q[res_idx].cnt),
    .taken_i (res_taken_i),
    .cnt_o   (upd_cnt)
  );

  // shifting through a HIST+1 wide vector keeps HIST = 1 legal
  assign restore_shift = {res_ghr_i, res_taken_i};
  assign spec_shift    = {ghr_q, spec_taken_i};

  always_comb begin
    table_d = table_q;
    if (flush_bp_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_d[i] = '{valid: 1'b0, cnt: WEAK_NT};
      end
    end else if (res_valid_i && !debug_mode_i) begin
      table_d[res_idx] = '{valid: 1'b1, cnt: upd_cnt};
    end
  end

  always_comb begin
    ghr_d = ghr_q;
    if (flush_bp_i) begin
      ghr_d = '0;
    end else if (debug_mode_i) begin
      ghr_d = ghr_q;
    end else if (res_valid_i && res_mispredict_i) begin
      ghr_d = restore_shift[HIST-1:0];
    end else if (spec_push_i) begin
      ghr_d = spec_shift[HIST-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, cnt: WEAK_NT};
      end
      ghr_q <= '0;
    end else begin
      table_q <= table_d;
      ghr_q   <= ghr_d;
    end
  end

endmodule

// File: tb/tb_gshare_bht.sv
// tb/tb_gshare_bht.sv - self-checking bench for gshare_bht against a behavioural model
module tb_gshare_bht;

  localparam int VLEN    = 32;
  localparam int ENTRIES = 32;
  localparam int HIST    = 3;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_bp_i;
  logic            debug_mode_i;
  logic [VLEN-1:0] vpc_i;
  logic            pred_valid_o;
  logic            pred_taken_o;
  logic [HIST-1:0] pred_ghr_o;
  logic            spec_push_i;
  logic            spec_taken_i;
  logic            res_valid_i;
  logic [VLEN-1:0] res_pc_i;
  logic            res_taken_i;
  logic            res_mispredict_i;
  logic [HIST-1:0] res_ghr_i;

  int checks   = 0;
  int failures = 0;

  bit m_valid [ENTRIES];
  int m_cnt   [ENTRIES];
  int m_ghr;

  gshare_bht #(.VLEN(VLEN), .ENTRIES(ENTRIES), .HIST(HIST), .RVC(1'b1)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_bp_i       (flush_bp_i),
    .debug_mode_i     (debug_mode_i),
    .vpc_i            (vpc_i),
    .pred_valid_o     (pred_valid_o),
    .pred_taken_o     (pred_taken_o),
    .pred_ghr_o       (pred_ghr_o),
    .spec_push_i      (spec_push_i),
    .spec_taken_i     (spec_taken_i),
    .res_valid_i      (res_valid_i),
    .res_pc_i         (res_pc_i),
    .res_taken_i      (res_taken_i),
    .res_mispredict_i (res_mispredict_i),
    .res_ghr_i        (res_ghr_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic int midx(input logic [31:0] pc, input int h);
    return (int'(pc >> 1) % ENTRIES) ^ h;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
    m_ghr = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic probe(input string tag, input logic [31:0] pc);
    int e;
    vpc_i = pc;
    #1;
    e = midx(pc, m_ghr);
    chk({tag, "_valid"}, 32'(pred_valid_o), 32'(m_valid[e]));
    chk({tag, "_taken"}, 32'(pred_taken_o), 32'(m_cnt[e] >= 2));
    chk({tag, "_ghr"},   32'(pred_ghr_o),   32'(m_ghr));
  endtask

  task automatic idle();
    flush_bp_i = 0; debug_mode_i = 0; spec_push_i = 0; spec_taken_i = 0;
    res_valid_i = 0; res_pc_i = '0; res_taken_i = 0; res_mispredict_i = 0; res_ghr_i = '0;
  endtask

  // advance one clock, updating the model from the inputs applied this cycle
  task automatic tick();
    int e;
    if (flush_bp_i) begin
      model_clear();
    end else begin
      if (res_valid_i && !debug_mode_i) begin
        e = midx(res_pc_i, int'(res_ghr_i));
        if (!m_valid[e]) m_cnt[e] = res_taken_i ? 2 : 1;
        else if (res_taken_i) m_cnt[e] = (m_cnt[e] == 3) ? 3 : m_cnt[e] + 1;
        else m_cnt[e] = (m_cnt[e] == 0) ? 0 : m_cnt[e] - 1;
        m_valid[e] = 1'b1;
      end
      if (!debug_mode_i) begin
        if (res_valid_i && res_mispredict_i) m_ghr = ((int'(res_ghr_i) << 1) | int'(res_taken_i)) % 8;
        else if (spec_push_i) m_ghr = ((m_ghr << 1) | int'(spec_taken_i)) % 8;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [2:0] h);
    res_valid_i = 1; res_pc_i = pc; res_taken_i = tk; res_ghr_i = h;
    tick();
    idle();
  endtask

  task automatic push(input logic tk);
    spec_push_i = 1; spec_taken_i = tk;
    tick();
    idle();
  endtask

  initial begin
    idle();
    vpc_i  = 32'h8000_0000;
    rst_ni = 1'b0;
    model_clear();
    #12;
    probe("reset", 32'h8000_0000);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    resolve(32'h8000_0004, 1, 3'b000);
    probe("alloc_t", 32'h8000_0004);
    for (int i = 0; i < 3; i++) resolve(32'h8000_0004, 1, 3'b000);
    probe("sat_hi", 32'h8000_0004);
    resolve(32'h8000_0004, 0, 3'b000);
    probe("dec_once", 32'h8000_0004);
    for (int i = 0; i < 4; i++) resolve(32'h8000_0004, 0, 3'b000);
    probe("sat_lo", 32'h8000_0004);

    for (int i = 0; i < 3; i++) push(1);
    probe("ghr_111", 32'h8000_0004);
    chk("ghr_111_val", 32'(pred_ghr_o), 32'd7);

    res_valid_i = 1; res_mispredict_i = 1; res_pc_i = 32'h8000_0004;
    res_ghr_i = 3'b010; res_taken_i = 0; spec_push_i = 1; spec_taken_i = 1;
    tick();
    idle();
    chk("restore_ghr", 32'(pred_ghr_o), 32'd4);
    probe("restore_entry", 32'h8000_0008);

    push(1); push(0); push(1);
    chk("ghr_101", 32'(pred_ghr_o), 32'd5);
    flush_bp_i = 1; res_valid_i = 1; res_pc_i = 32'h8000_0010; res_taken_i = 1;
    tick();
    idle();
    probe("flush_a", 32'h8000_0004);
    probe("flush_b", 32'h8000_0010);
    probe("flush_c", 32'h8000_0008);

    resolve(32'h8000_0020, 1, 3'b000);
    debug_mode_i = 1; res_valid_i = 1; res_pc_i = 32'h8000_0020; res_taken_i = 0;
    spec_push_i = 1; spec_taken_i = 1;
    tick();
    idle();
    probe("debug_hold", 32'h8000_0020);
    res_valid_i = 1; res_pc_i = 32'h8000_0020; res_taken_i = 0;
    probe("collide_old", 32'h8000_0020);
    tick();
    idle();
    probe("collide_new", 32'h8000_0020);

    for (int n = 0; n < 400; n++) begin
      flush_bp_i       = ($urandom_range(0, 49) == 0);
      debug_mode_i     = ($urandom_range(0, 9) == 0);
      spec_push_i      = $urandom_range(0, 1);
      spec_taken_i     = $urandom_range(0, 1);
      res_valid_i      = ($urandom_range(0, 3) != 0);
      res_pc_i         = 32'h8000_0000 | ($urandom & 32'h7e);
      res_taken_i      = $urandom_range(0, 1);
      res_mispredict_i = ($urandom_range(0, 4) == 0);
      res_ghr_i        = 3'($urandom);
      probe("rand", 32'h8000_0000 | ($urandom & 32'h7e));
      tick();
      if (n == 200) begin
        #2;
        rst_ni = 1'b0;
        model_clear();
        idle();
        probe("async_rst", 32'h8000_0004);
        rst_ni = 1'b1;
      end
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
